// File: rtl/elevator_call_scheduler.sv
// ----------------------------------------------------------------------------
// elevator_call_scheduler
//
// Per-car collective (SCAN) call scheduler sitting in front of the elevator
// FSM. Floor calls are latched into a pending bitmap. The car is steered up or
// down toward the nearest pending floor in its sweep direction. It is held
// with the door open for a dwell period at each served floor.
//
// Ports:
//   clk           clock
//   rst           asynchronous, active-low reset
//   call_req      one bit per floor; a high bit registers a call
//   door_hold     while high during a dwell, the dwell counter reloads
//   cur_floor     car position, fed back from the elevator floor output
//   target_floor  floor the car is driven toward
//   door_open     high throughout a dwell
//   dir_up        current/last sweep direction, 1 = up
//   pending       registered outstanding calls
//   served        one-cycle pulse on dwell entry
//   served_floor  floor served, valid with served, otherwise holds
//   busy          scheduler not idle
// ----------------------------------------------------------------------------
module elevator_call_scheduler #(
    parameter int NUM_FLOORS   = 8,
    parameter int FLOOR_W      = 3,
    parameter int DWELL_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] call_req,
    input  logic                  door_hold,
    input  logic [FLOOR_W-1:0]    cur_floor,
    output logic [FLOOR_W-1:0]    target_floor,
    output logic                  door_open,
    output logic                  dir_up,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  served,
    output logic [FLOOR_W-1:0]    served_floor,
    output logic                  busy
);

    localparam int               CNT_W        = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DWELL_RELOAD = CNT_W'(DWELL_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        MOVE_UP,
        MOVE_DOWN,
        DWELL
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      dwell_cnt;

    logic                  above;
    logic                  below;
    logic                  here;
    logic [FLOOR_W-1:0]    next_above;
    logic [FLOOR_W-1:0]    next_below;
    logic [NUM_FLOORS-1:0] clr;
    logic                  prefer_up;
    logic                  go_up;
    logic                  go_down;
    logic                  depart;

    // Nearest pending floor on each side of the car.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        above      = 1'b0;
        below      = 1'b0;
        next_above = cur_floor;
        next_below = cur_floor;
        // High-to-low scan: the last hit is the lowest floor above the car.
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && (i > int'(cur_floor))) begin
                above      = 1'b1;
                next_above = FLOOR_W'(i);
            end
        end
        // Low-to-high scan: the last hit is the highest floor below the car.
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i] && (i < int'(cur_floor))) begin
                below      = 1'b1;
                next_below = FLOOR_W'(i);
            end
        end
    end

    assign here = pending[cur_floor];

    // The floor being dwelled on (or just reached) swallows its own calls.
    assign clr = ((state == DWELL) || here) ? (NUM_FLOORS'(1) << cur_floor) : '0;

    // Direction preference: idle favours up, a moving car keeps its sweep,
    // a car leaving a dwell resumes the sweep it arrived with.
    always_comb begin
        prefer_up = 1'b1;
        case (state)
            MOVE_DOWN: prefer_up = 1'b0;
            DWELL:     prefer_up = dir_up;
            default:   prefer_up = 1'b1;
        endcase
    end

    assign go_up   = prefer_up ? above : (above && !below);
    assign go_down = prefer_up ? (below && !above) : below;

    // Routing decision is taken on dwell expiry, or in any non-dwell cycle
    // where the car is not standing on a pending floor.
    assign depart = (state == DWELL) ? (!door_hold && (dwell_cnt == '0)) : !here;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            pending      <= '0;
            target_floor <= '0;
            door_open    <= 1'b0;
            dir_up       <= 1'b1;
            served       <= 1'b0;
            served_floor <= '0;
            dwell_cnt    <= '0;
            busy         <= 1'b0;
        end else begin
            // NOTE: registered state uses non-blocking assignments so every read sees the pre-edge value.
            pending <= (pending | call_req) & ~clr;
            served  <= 1'b0;

            if ((state != DWELL) && here) begin
                state        <= DWELL;
                busy         <= 1'b1;
                door_open    <= 1'b1;
                served       <= 1'b1;
                served_floor <= cur_floor;
                target_floor <= cur_floor;
                dwell_cnt    <= DWELL_RELOAD;
            end else if (depart) begin
                door_open <= 1'b0;
                if (go_up) begin
                    state        <= MOVE_UP;
                    busy         <= 1'b1;
                    dir_up       <= 1'b1;
                    target_floor <= next_above;
                end else if (go_down) begin
                    state        <= MOVE_DOWN;
                    busy         <= 1'b1;
                    dir_up       <= 1'b0;
                    target_floor <= next_below;
                end else begin
                    state        <= IDLE;
                    busy         <= 1'b0;
                    target_floor <= cur_floor;
                end
            end else if (state == DWELL) begin
                if (door_hold) begin
                    dwell_cnt <= DWELL_RELOAD;
                end else begin
                    dwell_cnt <= dwell_cnt - CNT_W'(1);
                end
            end
        end
    end

endmodule
